// File: rtl/ft_memory.sv
// Fault-tolerance checkpoint memory: shadows the register file plus the PC and
// serves word reads over req/gnt/rvalid. Optional macro: FT_MEMORY_ZERO_R0_EN.
module ft_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_rf_i,
  input  logic [4:0]            addr_rf_i,
  input  logic [DATA_WIDTH-1:0] data_rf_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  input  logic [31:0]           addr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int          DEPTH   = NUM_REGS + 1;
  localparam int          IDX_W   = $clog2(DEPTH);
  localparam logic [29:0] MAX_IDX = 30'(NUM_REGS);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [29:0]      word_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             misaligned;
  logic             out_of_range;
  logic             wr_in_range;

  // Always ready: the grant is a pure function of the request, even in reset.
  assign gnt_o = req_i;

  always_comb begin
    word_idx     = addr_i[31:2];
    misaligned   = |addr_i[1:0];
    out_of_range = word_idx > MAX_IDX;
    rd_idx       = word_idx[IDX_W-1:0];
    wr_idx       = IDX_W'(addr_rf_i);
    wr_in_range  = int'(addr_rf_i) < NUM_REGS;
  end

  // Next-state of the storage array: RF shadow write, then PC capture.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves a signal unassigned would otherwise infer a latch.
    mem_d = mem_q;
    if (we_rf_i && wr_in_range) begin
`ifdef FT_MEMORY_ZERO_R0_EN
      if (addr_rf_i != '0) begin
        mem_d[wr_idx] = data_rf_i;
      end
`else
      mem_d[wr_idx] = data_rf_i;
`endif
    end
    mem_d[NUM_REGS] = pc_i;
  end

  // Read path samples mem_q, so a same-edge write is seen only on the next read.
  always_comb begin
    rvalid_d = req_i;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (req_i) begin
      if (misaligned || out_of_range) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end else begin
        rdata_d = mem_q[rd_idx];
        err_d   = 1'b0;
`ifdef FT_MEMORY_ZERO_R0_EN
        if (word_idx == '0) begin
          rdata_d = '0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the array is reset because a recovery agent must read zeros after
      // reset; this keeps the storage in flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // which is exactly what gives read-during-write its old-data result.
      mem_q    <= mem_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_ft_memory.sv
// Scoreboard bench for ft_memory: a reference array predicts each read when it
// is issued; a negedge monitor pops and compares responses, including latency.
module tb_ft_memory;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        we_rf_i = 1'b0;
  logic [4:0]  addr_rf_i = '0;
  logic [31:0] data_rf_i = '0;
  logic [31:0] pc_i = '0;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] addr_i = '0;
  logic [31:0] rdata_o;
  logic        err_o;

  ft_memory #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_rf_i  (we_rf_i),
    .addr_rf_i(addr_rf_i),
    .data_rf_i(data_rf_i),
    .pc_i     (pc_i),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .addr_i   (addr_i),
    .rdata_o  (rdata_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } resp_t;

  resp_t       sb [$];
  logic [31:0] model [33];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic resp_t predict(input logic [31:0] a);
    resp_t r;
    r.due = 0;
    if (a[1:0] != 2'b00 || a[31:2] > 30'd32) begin
      r.data = '0;
      r.err  = 1'b1;
    end else begin
      r.data = model[a[31:2]];
      r.err  = 1'b0;
    end
    return r;
  endfunction

  // One clock cycle: drive inputs, predict, update the model, cross the edge.
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rq, input logic [31:0] ra);
    resp_t r;
    we_rf_i   = we;
    addr_rf_i = wa;
    data_rf_i = wd;
    req_i     = rq;
    addr_i    = ra;
    #1;
    check("gnt", 32'(gnt_o), 32'(rq));
    if (rq) begin
      r     = predict(ra);
      r.due = cyc + 1;
      sb.push_back(r);
    end
`ifdef FT_MEMORY_ZERO_R0_EN
    if (we && wa != 5'd0) model[wa] = wd;
`else
    if (we) model[wa] = wd;
`endif
    model[32] = pc_i;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
  endtask

  always @(negedge clk_i) begin
    resp_t r;
    if (!rst_i) begin
      if (rvalid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_rvalid", 32'(rvalid_o), 32'd0);
        end else begin
          r = sb.pop_front();
          check("rdata", rdata_o, r.data);
          check("err", 32'(err_o), 32'(r.err));
          check("latency", 32'(cyc), 32'(r.due));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        r = sb.pop_front();
        check("rvalid_missing", 32'(rvalid_o), 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 33; i++) model[i] = '0;

    // Reset state, grant follows request during reset.
    req_i = 1'b1;
    #2;
    check("rst_gnt", 32'(gnt_o), 32'd1);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // First read after reset.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h0);
    idle();

    // Fill every register, then read all back-to-back.
    for (int i = 0; i < 32; i++) drive(1'b1, 5'(i), 32'h11111100 + 32'(i), 1'b0, 32'h0);
    for (int i = 0; i < 32; i++) drive(1'b0, 5'd0, 32'h0, 1'b1, 32'(i * 4));
    idle();

    // PC capture, and read-during-write of word 32.
    pc_i = 32'h00000ABC;
    idle();
    idle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h80);
    pc_i = 32'h00001234;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h80);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h80);

    // Error decode: misaligned, index 33, huge index, and last legal word.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h06);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h84);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h7C);

    // Read-during-write of register 5, then the new value.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'h14);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h14);
    idle();
    check("hold_rvalid", 32'(rvalid_o), 32'd0);
    check("hold_rdata", rdata_o, 32'hDEADBEEF);

    // Independent write and read of different words on the same edge.
    drive(1'b1, 5'd9, 32'hCAFEF00D, 1'b1, 32'h28);
    drive(1'b1, 5'd0, 32'h0BADC0DE, 1'b1, 32'h24);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h00);
    idle();

    // Reset while a response is pending.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 32'h1C);
    rst_i = 1'b1;
    #1;
    check("midrst_rvalid", 32'(rvalid_o), 32'd0);
    check("midrst_rdata", rdata_o, 32'd0);
    sb.delete();
    for (int i = 0; i < 33; i++) model[i] = '0;
    pc_i = 32'h0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Everything reads zero after reset.
    for (int i = 0; i <= 32; i++) drive(1'b0, 5'd0, 32'h0, 1'b1, 32'(i * 4));
    idle();
    idle();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ft_memory.md
Name: ft_memory

Overview:
- Fault-tolerance checkpoint memory alongside a core.
- Shadows the 32-entry integer register file plus the current PC in a 33-word array: words 0..31 are registers, word 32 is the PC.
- A recovery or checker agent reads any word back over a simple req/gnt/rvalid word-read port.
- Sits beside the core's writeback stage; it is never in the core's critical path.

Parameters:
DATA_WIDTH, 32, width of each stored word, pc_i, data_rf_i and rdata_o
NUM_REGS, 32, register-file entries; total depth is NUM_REGS+1 (last word = PC)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous active-high reset
we_rf_i  in  1  register-file shadow write enable
addr_rf_i  in  5  register index to write (0..31)
data_rf_i  in  32  register write data
pc_i  in  32  current PC, captured every cycle
req_i  in  1  read request
gnt_o  out  1  read grant
rvalid_o  out  1  read data valid
addr_i  in  32  byte address of read
rdata_o  out  32  read data
err_o  out  1  read error, qualified by rvalid_o

Behaviour:
- Reset (rst_i high, async): all 33 words cleared to 0; rvalid_o=0, rdata_o=0, err_o=0. gnt_o follows req_i even in reset.
- Storage: mem[0..NUM_REGS], DATA_WIDTH bits each.
- RF write: at a posedge with we_rf_i=1, mem[addr_rf_i] <= data_rf_i. All 32 indices are writable, including 0.
- PC capture: every posedge outside reset, mem[NUM_REGS] <= pc_i.
- Read handshake:
  - gnt_o = req_i, combinational; the block is always ready, with no wait states.
  - A granted request at posedge N produces rvalid_o=1 for exactly the cycle after edge N, with registered rdata_o and err_o.
  - Back-to-back requests on consecutive cycles are supported: one response per cycle, in order.
  - With no request, rvalid_o=0 next cycle; rdata_o and err_o hold their last values.
- Address decode: word index = addr_i[31:2].
  - err_o=1 and rdata_o=0 if addr_i[1:0]!=0 (misaligned).
  - err_o=1 and rdata_o=0 if word index > NUM_REGS (out of range).
  - Otherwise err_o=0 and rdata_o=mem[index].
- Read-during-write to the same word on the same edge returns the old (pre-write) value. This includes word 32, which is written every cycle.
- Reset asserted mid-transaction: pending rvalid_o is dropped (forced 0) and no response is issued for that request.
- Simultaneous RF write and read of different words: fully independent, no stall.

Optional Feature:
- Macro FT_MEMORY_ZERO_R0_EN.
- When defined:
  - Writes with addr_rf_i=0 are ignored.
  - mem[0] stays 0.
  - A read of address 0x0 returns 0 with err_o=0, matching x0 semantics.
- When undefined: word 0 is an ordinary storage word written like any other.

Test Plan:
- Reset, then req_i=1 at addr 0x0 -> gnt_o=1 same cycle; next cycle rvalid_o=1, rdata_o=0, err_o=0.
- we_rf_i=1 for 32 consecutive cycles, addr_rf_i=i, data_rf_i=0x11111100+i; then read addr i*4 back-to-back for i=0..31 -> rvalid_o every cycle with rdata_o=0x11111100+i, err_o=0. With FT_MEMORY_ZERO_R0_EN, i=0 returns 0.
- Hold pc_i=0x00000ABC for two cycles, then read addr 0x80 -> rdata_o=0x00000ABC, err_o=0.
- Read addr 0x06 (misaligned) and addr 0x84 (index 33) -> rvalid_o=1, err_o=1, rdata_o=0 for each.
- Same edge: we_rf_i=1, addr_rf_i=5, data_rf_i=0xDEADBEEF, and a read of 0x14 -> returns the old value. A read one cycle later returns 0xDEADBEEF.
- Assert rst_i while rvalid_o is pending -> rvalid_o=0 immediately. After reset, all words read 0.
